// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port, decode-side valid/ready stream and redirect input
// bundled for the fetch unit. master = fetch unit, slave = memory/decode/branch side.
interface instr_fetch_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] instr_addr;
  logic [DATA_WIDTH-1:0] instr_data;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_instr;
  logic [ADDR_WIDTH-1:0] out_pc;

  modport master (
    output instr_addr,
    input  instr_data,
    input  redirect_valid,
    input  redirect_pc,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  instr_addr,
    output instr_data,
    output redirect_valid,
    output redirect_pc,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch unit: owns the fetch PC, captures same-cycle instruction data into an
// in-order {pc, instr} buffer and streams it to decode; redirect flushes and restarts.
module instr_fetch_unit #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter int                    FIFO_DEPTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  instr_fetch_unit_if.master  bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;

  logic [ADDR_WIDTH-1:0] pc_mem    [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] instr_mem [FIFO_DEPTH];

  logic not_empty;
  logic pop;
  logic push;

  assign not_empty = (count != '0);
  assign pop       = not_empty & bus.out_ready;
  // A full buffer still accepts a fetch when the head leaves in the same cycle.
  assign push      = ~bus.redirect_valid & ((count < FULL_COUNT) | pop);

  assign bus.instr_addr = fetch_pc;
  assign bus.out_valid  = not_empty;
  assign bus.out_instr  = not_empty ? instr_mem[rd_ptr] : '0;
  assign bus.out_pc     = not_empty ? pc_mem[rd_ptr]    : '0;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (bus.redirect_valid) begin
      // Any pop in this cycle is dropped together with the rest of the buffer.
      fetch_pc <= {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        fetch_pc <= fetch_pc + PC_STEP;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; count gates out_valid, so stale
  // contents are never observable and the array can map onto plain flops/RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= fetch_pc;
      instr_mem[wr_ptr] <= bus.instr_data;
    end
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, backpressure, full drain,
// redirect, async reset and PC wrap-around.
module tb_instr_fetch_unit;
  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst2 = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  instr_fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus1 ();
  instr_fetch_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus2 ();

  // Memory model: word i holds 0x1000 + i.
  assign bus1.instr_data = 32'h1000 + (bus1.instr_addr >> 2);
  assign bus2.instr_data = 32'h1000 + (bus2.instr_addr >> 2);

  instr_fetch_unit #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'h0), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus1.master)
  );

  instr_fetch_unit #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)
  ) dut_wrap (
    .clk(clk), .rst(rst2), .bus(bus2.master)
  );

  task automatic apply_reset();
    rst                 = 1'b1;
    bus1.out_ready      = 1'b0;
    bus1.redirect_valid = 1'b0;
    bus1.redirect_pc    = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst                 = 1'b1;
    bus1.out_ready      = 1'b0;
    bus1.redirect_valid = 1'b0;
    bus1.redirect_pc    = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus1.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 0", bus1.out_valid);
    end
    n_checks++;
    if (bus1.out_instr !== 32'h0) begin
      n_fail++; $display("FAIL reset_instr: got %h expected 00000000", bus1.out_instr);
    end
    n_checks++;
    if (bus1.out_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_pc: got %h expected 00000000", bus1.out_pc);
    end
    n_checks++;
    if (bus1.instr_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr: got %h expected 00000000", bus1.instr_addr);
    end
    rst = 1'b0;
  endtask

  // Stream with out_ready high: one instruction per cycle, no bubbles.
  task automatic test_stream();
    logic [31:0] exp_pc;
    bus1.out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      exp_pc = 32'(4 * (k - 1));
      n_checks++;
      if (bus1.out_valid !== 1'b1) begin
        n_fail++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, bus1.out_valid);
      end
      n_checks++;
      if (bus1.out_pc !== exp_pc) begin
        n_fail++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, bus1.out_pc, exp_pc);
      end
      n_checks++;
      if (bus1.out_instr !== 32'h1000 + 32'(k - 1)) begin
        n_fail++; $display("FAIL stream_instr[%0d]: got %h expected %h", k, bus1.out_instr,
                           32'h1000 + 32'(k - 1));
      end
      n_checks++;
      if (bus1.instr_addr !== 32'(4 * k)) begin
        n_fail++; $display("FAIL stream_addr[%0d]: got %h expected %h", k, bus1.instr_addr,
                           32'(4 * k));
      end
    end
  endtask

  // Hold out_ready low: buffer fills to 4, address stalls at 0x10, head stays at pc 0.
  task automatic test_backpressure();
    logic [31:0] exp_addr;
    apply_reset();
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_addr = (k < 4) ? 32'(4 * k) : 32'h10;
      n_checks++;
      if (bus1.instr_addr !== exp_addr) begin
        n_fail++; $display("FAIL stall_addr[%0d]: got %h expected %h", k, bus1.instr_addr, exp_addr);
      end
      n_checks++;
      if (bus1.out_valid !== 1'b1 || bus1.out_pc !== 32'h0 || bus1.out_instr !== 32'h1000) begin
        n_fail++; $display("FAIL stall_head[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=0 instr=1000",
                           k, bus1.out_valid, bus1.out_pc, bus1.out_instr);
      end
    end
    n_checks++;
    if (dut.count !== 3'd4) begin
      n_fail++; $display("FAIL stall_count: got %0d expected 4", dut.count);
    end
  endtask

  // From FULL with out_ready high: push and pop every cycle, count pinned at 4.
  task automatic test_full_drain();
    bus1.out_ready = 1'b1;
    for (int j = 1; j <= 6; j++) begin
      @(negedge clk);
      n_checks++;
      if (bus1.out_pc !== 32'(4 * j)) begin
        n_fail++; $display("FAIL drain_pc[%0d]: got %h expected %h", j, bus1.out_pc, 32'(4 * j));
      end
      n_checks++;
      if (bus1.out_instr !== 32'h1000 + 32'(j)) begin
        n_fail++; $display("FAIL drain_instr[%0d]: got %h expected %h", j, bus1.out_instr,
                           32'h1000 + 32'(j));
      end
      n_checks++;
      if (dut.count !== 3'd4) begin
        n_fail++; $display("FAIL drain_count[%0d]: got %0d expected 4", j, dut.count);
      end
      n_checks++;
      if (bus1.instr_addr !== 32'h10 + 32'(4 * j)) begin
        n_fail++; $display("FAIL drain_addr[%0d]: got %h expected %h", j, bus1.instr_addr,
                           32'h10 + 32'(4 * j));
      end
    end
  endtask

  // Redirect to 0x203 with three entries buffered and a concurrent pop.
  task automatic test_redirect();
    apply_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (dut.count !== 3'd3) begin
      n_fail++; $display("FAIL redir_precount: got %0d expected 3", dut.count);
    end
    bus1.out_ready      = 1'b1;
    bus1.redirect_valid = 1'b1;
    bus1.redirect_pc    = 32'h203;
    @(negedge clk);
    bus1.redirect_valid = 1'b0;
    n_checks++;
    if (bus1.out_valid !== 1'b0 || bus1.out_pc !== 32'h0 || bus1.out_instr !== 32'h0) begin
      n_fail++; $display("FAIL redir_flush: got v=%b pc=%h instr=%h expected v=0 pc=0 instr=0",
                         bus1.out_valid, bus1.out_pc, bus1.out_instr);
    end
    n_checks++;
    if (bus1.instr_addr !== 32'h200) begin
      n_fail++; $display("FAIL redir_addr: got %h expected 00000200", bus1.instr_addr);
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      n_checks++;
      if (bus1.out_valid !== 1'b1 || bus1.out_pc !== 32'h200 + 32'(4 * j)
          || bus1.out_instr !== 32'h1080 + 32'(j)) begin
        n_fail++; $display("FAIL redir_seq[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                           j, bus1.out_valid, bus1.out_pc, bus1.out_instr,
                           32'h200 + 32'(4 * j), 32'h1080 + 32'(j));
      end
    end
  endtask

  // Two consecutive redirects: the second target wins.
  task automatic test_back_to_back();
    bus1.redirect_valid = 1'b1;
    bus1.redirect_pc    = 32'h400;
    @(negedge clk);
    bus1.redirect_pc    = 32'h82;
    @(negedge clk);
    bus1.redirect_valid = 1'b0;
    n_checks++;
    if (bus1.out_valid !== 1'b0 || bus1.instr_addr !== 32'h80) begin
      n_fail++; $display("FAIL b2b_flush: got v=%b addr=%h expected v=0 addr=00000080",
                         bus1.out_valid, bus1.instr_addr);
    end
    @(negedge clk);
    n_checks++;
    if (bus1.out_valid !== 1'b1 || bus1.out_pc !== 32'h80 || bus1.out_instr !== 32'h1020) begin
      n_fail++; $display("FAIL b2b_first: got v=%b pc=%h instr=%h expected v=1 pc=00000080 instr=00001020",
                         bus1.out_valid, bus1.out_pc, bus1.out_instr);
    end
  endtask

  // Reset asserted between edges must take effect without a clock.
  task automatic test_async_reset();
    @(negedge clk);
    n_checks++;
    if (bus1.out_valid !== 1'b1) begin
      n_fail++; $display("FAIL arst_pre: got %b expected 1", bus1.out_valid);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if (bus1.out_valid !== 1'b0 || bus1.out_pc !== 32'h0 || bus1.instr_addr !== 32'h0) begin
      n_fail++; $display("FAIL arst_now: got v=%b pc=%h addr=%h expected v=0 pc=0 addr=0",
                         bus1.out_valid, bus1.out_pc, bus1.instr_addr);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus1.out_pc !== 32'(4 * (k - 1)) || bus1.instr_addr !== 32'(4 * k)) begin
        n_fail++; $display("FAIL arst_restart[%0d]: got pc=%h addr=%h expected pc=%h addr=%h",
                           k, bus1.out_pc, bus1.instr_addr, 32'(4 * (k - 1)), 32'(4 * k));
      end
    end
  endtask

  // RESET_PC near the top of the address space: fetch PC wraps to 0.
  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    logic [31:0] exp_instr [3];
    exp_pc[0] = 32'hFFFF_FFF8; exp_instr[0] = 32'h4000_0FFE;
    exp_pc[1] = 32'hFFFF_FFFC; exp_instr[1] = 32'h4000_0FFF;
    exp_pc[2] = 32'h0000_0000; exp_instr[2] = 32'h0000_1000;
    rst2 = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus2.instr_addr !== 32'hFFFF_FFF8 || bus2.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL wrap_reset: got addr=%h v=%b expected addr=fffffff8 v=0",
                         bus2.instr_addr, bus2.out_valid);
    end
    rst2 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus2.out_valid !== 1'b1 || bus2.out_pc !== exp_pc[k] || bus2.out_instr !== exp_instr[k]) begin
        n_fail++; $display("FAIL wrap_seq[%0d]: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h",
                           k, bus2.out_valid, bus2.out_pc, bus2.out_instr, exp_pc[k], exp_instr[k]);
      end
    end
  endtask

  initial begin
    bus2.out_ready      = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_drain();
    test_redirect();
    test_back_to_back();
    test_async_reset();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
